// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller.
// Holds board geometry, spawn position, the shape enum, FSM/move enums and
// the per-shape cell offset table with helpers for rotation, LFSR stepping
// and mapping an LFSR value to a shape.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int SPAWN_X = 4;
    localparam int SPAWN_Y = 18;
    localparam int OFF_Y   = 20;   // anchor row used while no piece is live

    // Codes are chosen so a nonzero LFSR value selects the shape directly
    // (seed 1 gives I); the LFSR value 7 folds onto code 0 (L).
    typedef enum logic [2:0] {
        SHAPE_L = 3'd0, SHAPE_I = 3'd1, SHAPE_O = 3'd2, SHAPE_T = 3'd3,
        SHAPE_S = 3'd4, SHAPE_Z = 3'd5, SHAPE_J = 3'd6
    } shape_t;

    typedef enum logic [1:0] {ST_SPAWN, ST_FALL, ST_WAIT_LOCK, ST_OVER} state_t;

    typedef enum logic [2:0] {MV_NONE, MV_ROT, MV_LEFT, MV_RIGHT, MV_DROP, MV_GRAV} move_t;

    typedef struct packed {
        logic rot;
        logic left;
        logic right;
        logic drop;
    } keys_t;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } offset_t;

    // Rotation-0 cell offsets, indexed by shape code; y grows upward.
    localparam logic signed [2:0] BASE_DX [7][4] = '{
        '{-3'sd1,  3'sd0,  3'sd1,  3'sd1},   // L
        '{-3'sd1,  3'sd0,  3'sd1,  3'sd2},   // I
        '{ 3'sd0,  3'sd1,  3'sd0,  3'sd1},   // O
        '{-3'sd1,  3'sd0,  3'sd1,  3'sd0},   // T
        '{-3'sd1,  3'sd0,  3'sd0,  3'sd1},   // S
        '{-3'sd1,  3'sd0,  3'sd0,  3'sd1},   // Z
        '{-3'sd1, -3'sd1,  3'sd0,  3'sd1}    // J
    };
    localparam logic signed [2:0] BASE_DY [7][4] = '{
        '{ 3'sd0,  3'sd0,  3'sd0,  3'sd1},   // L
        '{ 3'sd0,  3'sd0,  3'sd0,  3'sd0},   // I
        '{ 3'sd0,  3'sd0, -3'sd1, -3'sd1},   // O
        '{ 3'sd0,  3'sd0,  3'sd0,  3'sd1},   // T
        '{ 3'sd0,  3'sd0,  3'sd1,  3'sd1},   // S
        '{ 3'sd1,  3'sd1,  3'sd0,  3'sd0},   // Z
        '{ 3'sd1,  3'sd0,  3'sd0,  3'sd0}    // J
    };

    // The full shape x rotation table: each quarter turn maps (dx,dy) to (dy,-dx).
    function automatic offset_t cell_offset(input shape_t shape, input logic [1:0] rot,
                                            input int idx);
        offset_t           o;
        logic signed [2:0] t;
        o.dx = BASE_DX[shape][idx];
        o.dy = BASE_DY[shape][idx];
        for (int r = 0; r < 3; r++) begin
            if (r < int'(rot)) begin
                t    = o.dx;
                o.dx = o.dy;
                o.dy = -t;
            end
        end
        return o;
    endfunction

    // x^3 + x^2 + 1 Fibonacci LFSR; the all-zero lockup state is forced out.
    function automatic logic [2:0] lfsr_step(input logic [2:0] v);
        return (v == 3'd0) ? 3'd1 : {v[1:0], v[2] ^ v[1]};
    endfunction

    function automatic shape_t shape_of(input logic [2:0] v);
        return (v == 3'd7) ? SHAPE_L : shape_t'(v);
    endfunction

endpackage

// File: rtl/piece_fit_check.sv
// Combinational placement check for one piece position.
// Ports:
//   shape, rot, ax, ay : piece shape, rotation and anchor
//   board              : occupancy, board[y][x], row 0 at the bottom
//   legal              : all four cells on the board and on empty squares
//   cx, cy             : the four cell coordinates (low bits of the sums)
module piece_fit_check
    import tetris_pkg::*;
(
    input  shape_t                          shape,
    input  logic [1:0]                      rot,
    input  logic [4:0]                      ax,
    input  logic [5:0]                      ay,
    input  logic [BOARD_H-1:0][BOARD_W-1:0] board,
    output logic                            legal,
    output logic [3:0][4:0]                 cx,
    output logic [3:0][5:0]                 cy
);

    localparam logic signed [7:0] MAX_X = 8'(BOARD_W - 1);
    localparam logic signed [7:0] MAX_Y = 8'(BOARD_H - 1);

    always_comb begin
        offset_t           off;
        logic signed [7:0] x;
        logic signed [7:0] y;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        legal = 1'b1;
        cx    = '0;
        cy    = '0;
        for (int i = 0; i < 4; i++) begin
            off = cell_offset(shape, rot, i);
            // Signed arithmetic so cells pushed past column/row 0 read as negative.
            x = $signed({3'b000, ax}) + 8'(off.dx);
            y = $signed({2'b00, ay}) + 8'(off.dy);
            if (x < 8'sd0 || x > MAX_X || y < 8'sd0 || y > MAX_Y) begin
                legal = 1'b0;
            end else if (board[y[4:0]][x[3:0]]) begin
                legal = 1'b0;
            end
            cx[i] = x[4:0];
            cy[i] = y[5:0];
        end
    end

endmodule

// File: rtl/piece_controller.sv
// Falling-piece controller: spawns pieces from an LFSR, applies key moves
// and gravity once per frame tick (rising edge of vs), and hands the piece
// to the board memory through lock/stop.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   vs                                 : vertical sync, one frame tick per rising edge
//   key_left/right/rot/drop            : level key requests (edge-detected)
//   board                              : occupancy, board[y][x]
//   lock, stop                         : board memory locking / busy
//   x0..x3, y0..y3                     : registered piece cell coordinates
//   piece_valid, game_over             : live piece flag, sticky spawn-collision flag
module piece_controller
    import tetris_pkg::*;
#(
    parameter int         GRAVITY_FRAMES = 30,
    parameter logic [2:0] LFSR_SEED      = 3'b001
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            vs,
    input  logic                            key_left,
    input  logic                            key_right,
    input  logic                            key_rot,
    input  logic                            key_drop,
    input  logic [BOARD_H-1:0][BOARD_W-1:0] board,
    input  logic                            lock,
    input  logic                            stop,
    output logic [4:0]                      x0,
    output logic [4:0]                      x1,
    output logic [4:0]                      x2,
    output logic [4:0]                      x3,
    output logic [5:0]                      y0,
    output logic [5:0]                      y1,
    output logic [5:0]                      y2,
    output logic [5:0]                      y3,
    output logic                            piece_valid,
    output logic                            game_over
);

    localparam int               CNT_W   = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAVITY_FRAMES - 1);
    localparam logic [2:0]       SEED    = (LFSR_SEED == 3'd0) ? 3'd1 : LFSR_SEED;

    state_t           state, state_next;
    logic [2:0]       lfsr, lfsr_next;
    shape_t           shape, shape_next;
    logic [1:0]       rot, rot_next;
    logic [4:0]       ax, ax_next;
    logic [5:0]       ay, ay_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    keys_t            pend, pend_next, pend_eff, key_now, key_q, key_edge;
    logic             vs_q, tick, eval_cand;
    move_t            move;

    shape_t           fit_shape;
    logic [1:0]       fit_rot;
    logic [4:0]       fit_ax;
    logic [5:0]       fit_ay;
    logic             fit_legal;
    logic [3:0][4:0]  fit_cx, x_q;
    logic [3:0][5:0]  fit_cy, y_q;

    assign key_now  = '{rot: key_rot, left: key_left, right: key_right, drop: key_drop};
    assign key_edge = keys_t'(key_now & ~key_q);
    assign tick     = vs & ~vs_q;
    assign pend_eff = keys_t'(pend | key_edge);

    // One checker, time-shared: it evaluates the candidate on an acting tick
    // and the current piece (for the outputs) on every other cycle.
    piece_fit_check u_fit (
        .shape (fit_shape),
        .rot   (fit_rot),
        .ax    (fit_ax),
        .ay    (fit_ay),
        .board (board),
        .legal (fit_legal),
        .cx    (fit_cx),
        .cy    (fit_cy)
    );

    always_comb begin
        move = MV_NONE;
        if      (pend_eff.rot)   move = MV_ROT;
        else if (pend_eff.left)  move = MV_LEFT;
        else if (pend_eff.right) move = MV_RIGHT;
        else if (pend_eff.drop)  move = MV_DROP;
        else if (cnt == CNT_MAX) move = MV_GRAV;
    end

    always_comb begin
        eval_cand = tick && (state == ST_SPAWN || (state == ST_FALL && !stop && !lock));
        fit_shape = shape;
        fit_rot   = rot;
        fit_ax    = ax;
        fit_ay    = ay;
        if (eval_cand) begin
            if (state == ST_SPAWN) begin
                fit_shape = shape_of(lfsr);
                fit_rot   = 2'd0;
                fit_ax    = 5'(SPAWN_X);
                fit_ay    = 6'(SPAWN_Y);
            end else begin
                case (move)
                    MV_ROT:           fit_rot = rot + 2'd1;
                    MV_LEFT:          fit_ax  = ax - 5'd1;
                    MV_RIGHT:         fit_ax  = ax + 5'd1;
                    MV_DROP, MV_GRAV: fit_ay  = ay - 6'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        shape_next = shape;
        rot_next   = rot;
        ax_next    = ax;
        ay_next    = ay;
        cnt_next   = cnt;
        pend_next  = pend;
        case (state)
            ST_SPAWN: if (tick) begin
                lfsr_next = lfsr_step(lfsr);
                if (fit_legal) begin
                    state_next = ST_FALL;
                    shape_next = fit_shape;
                    rot_next   = 2'd0;
                    ax_next    = fit_ax;
                    ay_next    = fit_ay;
                    cnt_next   = '0;
                    pend_next  = '0;
                end else begin
                    state_next = ST_OVER;
                end
            end
            ST_FALL: begin
                if (lock) begin
                    // Lock beats any same-tick key: the piece is gone, requests dropped.
                    state_next = ST_WAIT_LOCK;
                    ay_next    = 6'(OFF_Y);
                    pend_next  = '0;
                end else if (!stop) begin
                    pend_next = pend_eff;
                    if (tick) begin
                        pend_next = '0;
                        cnt_next  = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                        // Illegal candidates, and gravity at the floor, leave the piece as is.
                        if (move != MV_NONE && fit_legal) begin
                            rot_next = fit_rot;
                            ax_next  = fit_ax;
                            ay_next  = fit_ay;
                            if (move == MV_DROP) cnt_next = '0;
                        end
                    end
                end
            end
            ST_WAIT_LOCK: if (tick && !stop && !lock) state_next = ST_SPAWN;
            default: ;   // ST_OVER holds until reset
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_SPAWN;
            lfsr  <= SEED;
            shape <= shape_of(SEED);
            rot   <= 2'd0;
            ax    <= 5'd0;
            ay    <= 6'(OFF_Y);
            cnt   <= '0;
            pend  <= '0;
            key_q <= '0;
            vs_q  <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            shape <= shape_next;
            rot   <= rot_next;
            ax    <= ax_next;
            ay    <= ay_next;
            cnt   <= cnt_next;
            pend  <= pend_next;
            key_q <= key_now;
            vs_q  <= vs;
        end
    end

    // Outputs follow the state one clock later; on an acting tick the checker
    // is busy with the candidate, so the cells hold for that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            piece_valid <= 1'b0;
            game_over   <= 1'b0;
            x_q         <= '0;
            y_q         <= {4{6'(OFF_Y)}};
        end else begin
            piece_valid <= (state == ST_FALL);
            game_over   <= (state == ST_OVER);
            if (state != ST_FALL) begin
                x_q <= '0;
                y_q <= {4{6'(OFF_Y)}};
            end else if (!eval_cand) begin
                x_q <= fit_cx;
                y_q <= fit_cy;
            end
        end
    end

    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];

endmodule

// File: tb/tb_piece_controller.sv
// Directed testbench for piece_controller with hand-computed expectations.
module tb_piece_controller;

    logic              clk = 1'b0;
    logic              reset;
    logic              vs;
    logic              key_left, key_right, key_rot, key_drop;
    logic [19:0][9:0]  board;
    logic              lock, stop;
    logic [4:0]        x0, x1, x2, x3;
    logic [5:0]        y0, y1, y2, y3;
    logic              piece_valid, game_over;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    piece_controller #(.GRAVITY_FRAMES(30), .LFSR_SEED(3'b001)) dut (
        .clk         (clk),
        .reset       (reset),
        .vs          (vs),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_rot     (key_rot),
        .key_drop    (key_drop),
        .board       (board),
        .lock        (lock),
        .stop        (stop),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .piece_valid (piece_valid),
        .game_over   (game_over)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_cells(input string tag,
                               input int ex0, input int ex1, input int ex2, input int ex3,
                               input int ey0, input int ey1, input int ey2, input int ey3);
        check({tag, ".x0"}, 32'(x0), ex0);
        check({tag, ".x1"}, 32'(x1), ex1);
        check({tag, ".x2"}, 32'(x2), ex2);
        check({tag, ".x3"}, 32'(x3), ex3);
        check({tag, ".y0"}, 32'(y0), ey0);
        check({tag, ".y1"}, 32'(y1), ey1);
        check({tag, ".y2"}, 32'(y2), ey2);
        check({tag, ".y3"}, 32'(y3), ey3);
    endtask

    // One frame tick: vs high for three clocks, low for three; outputs settle well before return.
    task automatic tick();
        @(negedge clk) vs = 1'b1;
        repeat (3) @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic r, input logic l, input logic rt, input logic d);
        @(negedge clk);
        key_rot = r; key_left = l; key_right = rt; key_drop = d;
        repeat (2) @(negedge clk);
        key_rot = 1'b0; key_left = 1'b0; key_right = 1'b0; key_drop = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; vs = 1'b0; lock = 1'b0; stop = 1'b0; board = '0;
        key_left = 1'b0; key_right = 1'b0; key_rot = 1'b0; key_drop = 1'b0;
        do_reset();

        // Reset state
        check("rst.valid", 32'(piece_valid), 0);
        check("rst.over",  32'(game_over), 0);
        check_cells("rst", 0, 0, 0, 0, 20, 20, 20, 20);

        // First spawn with seed 1: I, horizontal, row 18, columns 3..6
        tick();
        check("spawn.valid", 32'(piece_valid), 1);
        check("spawn.over",  32'(game_over), 0);
        check_cells("spawn", 3, 4, 5, 6, 18, 18, 18, 18);

        // Gravity: nothing for 29 ticks, one row down on tick 30
        ticks(29);
        check("grav29.y0", 32'(y0), 18);
        tick();
        check_cells("grav30", 3, 4, 5, 6, 17, 17, 17, 17);

        // Walk to the left wall, then bump it
        press(0, 1, 0, 0); tick();
        press(0, 1, 0, 0); tick();
        press(0, 1, 0, 0); tick();
        check("left3.x0", 32'(x0), 0);
        press(0, 1, 0, 0); tick();
        check_cells("wall", 0, 1, 2, 3, 17, 17, 17, 17);
        // A stale left request would outrank right; right moving proves it was cleared.
        press(0, 0, 1, 0); tick();
        check("right.x0", 32'(x0), 1);
        check("right.x3", 32'(x3), 4);

        // Rotate and left in the same frame: only the rotation happens (anchor (2,17))
        press(1, 1, 0, 0); tick();
        check_cells("rot", 2, 2, 2, 2, 18, 17, 16, 15);
        tick();
        check_cells("rot_next", 2, 2, 2, 2, 18, 17, 16, 15);

        // Soft drop: one row down, gravity counter restarts
        press(0, 0, 0, 1); tick();
        check_cells("drop", 2, 2, 2, 2, 17, 16, 15, 14);

        // Gravity counter frozen while stop is high
        ticks(20);
        check("pre_stop.y0", 32'(y0), 17);
        stop = 1'b1;
        ticks(10);
        check("stop.y0", 32'(y0), 17);
        check("stop.x0", 32'(x0), 2);
        stop = 1'b0;
        ticks(9);
        check("post_stop29.y0", 32'(y0), 17);
        tick();
        check_cells("post_stop30", 2, 2, 2, 2, 16, 15, 14, 13);

        // Lock hand-off
        stop = 1'b1;
        @(negedge clk) lock = 1'b1;
        @(negedge clk) lock = 1'b0;
        repeat (3) @(negedge clk);
        check("lock.valid", 32'(piece_valid), 0);
        check_cells("lock", 0, 0, 0, 0, 20, 20, 20, 20);
        ticks(2);
        check("lock_stop.valid", 32'(piece_valid), 0);
        stop = 1'b0;
        ticks(2);
        // Second LFSR value 2 gives O at anchor (4,18)
        check("respawn.valid", 32'(piece_valid), 1);
        check_cells("respawn", 4, 5, 4, 5, 18, 18, 17, 17);

        // Reset mid-fall drops the piece at once; the LFSR restarts from the seed
        @(negedge clk) reset = 1'b1;
        #1;
        check("midrst.valid", 32'(piece_valid), 0);
        check("midrst.y0", 32'(y0), 20);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        check("midrst_spawn.valid", 32'(piece_valid), 1);
        check_cells("midrst_spawn", 3, 4, 5, 6, 18, 18, 18, 18);

        // Spawn collision: rows 17..19 full
        @(negedge clk) reset = 1'b1;
        board[17] = '1; board[18] = '1; board[19] = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        check("over.game_over", 32'(game_over), 1);
        check("over.valid", 32'(piece_valid), 0);
        check("over.y0", 32'(y0), 20);
        board = '0;
        press(0, 1, 0, 0);
        ticks(3);
        check("over_hold.game_over", 32'(game_over), 1);
        check("over_hold.valid", 32'(piece_valid), 0);
        check_cells("over_hold", 0, 0, 0, 0, 20, 20, 20, 20);
        do_reset();
        check("over_rst.game_over", 32'(game_over), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/piece_controller.md
PIECE_CONTROLLER -- requirements
Module: piece_controller

Interface
REQ-001 Parameter GRAVITY_FRAMES, default 30: number of accepted frame ticks per automatic one-row drop.
REQ-002 Parameter LFSR_SEED, default 3'b001: piece-select LFSR value loaded at reset.
REQ-003 Port clk, input, 1: the single clock; one clock, all state on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port vs, input, 1: vertical sync; each rising edge, detected in the clk domain, is one frame tick.
REQ-006 Ports key_left, key_right, key_rot, key_drop, input, 1 each: level key requests.
REQ-007 Port board, input, 10 bits x 20: occupancy, where board[y][x] is row y (0 = bottom) and column x.
REQ-008 Ports lock and stop, input, 1 each: board-memory status; lock means the piece is written into board, stop means the board is busy locking or clearing.
REQ-009 Ports x0..x3, output, 5 each: piece cell columns.
REQ-010 Ports y0..y3, output, 6 each: piece cell rows.
REQ-011 Port piece_valid, output, 1: cells describe a live falling piece.
REQ-012 Port game_over, output, 1: spawn collided; sticky until reset.

Function
REQ-013 Piece shape shall be anchor (ax 5b, ay 6b) plus rotation-dependent offsets taken from a shape table covering 7 shapes (I,O,T,S,Z,J,L) x 4 rotations.
REQ-014 A candidate position is legal iff all 4 cells have 0<=x<=9, 0<=y<=19, and board[y][x]==0.
REQ-015 The FSM shall have states SPAWN, FALL, WAIT_LOCK and OVER; actions are taken only on frame ticks.
REQ-016 SPAWN: shape = LFSR value, anchor (4,18), rotation 0; if legal, go to FALL with piece_valid=1, else go to OVER with game_over=1; advance the LFSR (x^3+x^2+1, skip 0; value 7 maps to shape 0).
REQ-017 In FALL, a key press (0->1 edge) shall set a pending flag that holds until the next frame tick; at most one move is applied per tick.
REQ-018 Move priority shall be rot > left > right > drop > gravity.
REQ-019 rot: rotation+1 mod 4.
REQ-020 left/right: ax -/+ 1.
REQ-021 drop: ay-1, which also resets the gravity counter.
REQ-022 An illegal candidate shall be discarded with no change; the pending flag is still cleared.
REQ-023 The gravity counter shall increment per tick in FALL; at GRAVITY_FRAMES-1 it wraps to 0 and attempts ay-1; if that is illegal or any cell has y==0, the position is held.
REQ-024 While stop==1, no move or gravity shall apply; pending flags and the counter shall be held.
REQ-025 lock==1 on any clk edge in FALL shall cause a transition to WAIT_LOCK and drive piece_valid=0.
REQ-026 WAIT_LOCK shall go to SPAWN on the first frame tick with stop==0 and lock==0.
REQ-027 When piece_valid==0, outputs shall hold ay=20 so all y0..y3 >= 20 (off-board).
REQ-028 Outputs shall be registered and update one clk after the frame-tick edge is detected.
REQ-029 OVER shall be terminal until reset.
REQ-030 A key press and lock in the same tick: lock wins and the pending flags are cleared.

Reset
REQ-031 On reset, the FSM shall enter SPAWN with LFSR=LFSR_SEED.
REQ-032 On reset, the counter, pending flags and rotation shall be 0.
REQ-033 On reset, outputs shall be piece_valid=0, game_over=0, x0..x3=0 and y0..y3=20.
REQ-034 Reset asserted mid-fall shall abandon the piece immediately; the first spawn shall occur on the first frame tick after release.

Structure
REQ-035 tetris_pkg shall hold the shape enum, offset table, BOARD_W=10, BOARD_H=20, SPAWN_X=4 and SPAWN_Y=18.
REQ-036 One sub-module, piece_fit_check, shall be used: combinational; it takes shape, rotation, anchor and board, and returns legal plus the 4 cell coordinates.
REQ-037 The block shall be instantiated twice logically (current and candidate) or time-shared via one mux.

Verification
REQ-038 Reset, then one vs tick with seed 1 -> shape I at rotation 0, piece_valid=1, cells in row 18 columns 3..6, game_over=0.
REQ-039 Empty board, 30 vs ticks with no keys -> all y decrease by exactly 1, at tick 30 only.
REQ-040 Piece against column 0, key_left pulse then tick -> x unchanged, pending flag cleared.
REQ-041 key_rot and key_left pressed in the same frame, both legal -> only rotation applied that tick.
REQ-042 stop=1 for 10 ticks -> no motion and the gravity counter frozen; lock pulse -> piece_valid=0, y=20, new spawn on the next tick after stop falls.
REQ-043 Board rows 17..19 full, then spawn -> game_over=1, OVER held, no output change until reset.
